// File: rtl/debounce_counter.sv
// debounce_counter: debounces a raw push-button level and counts accepted presses.
//
// A press is accepted after the sampled button has been high for DEBOUNCE+2
// consecutive samples, starting from idle. A release is accepted the same way
// on the low level. Short glitches in either direction are rejected.
//
// Optional build macro: DEBOUNCE_COUNTER_SYNC_EN
//   defined   -> BTN passes through a two-flop synchronizer first (+2 cycles latency)
//   undefined -> the FSM samples BTN directly
//
// Parameters:
//   WIDTH    - width of the press counter COUNT
//   DEBOUNCE - stable-sample threshold compared against the 32-bit timer
//
// Ports:
//   CLK   - system clock, rising edge
//   RST   - synchronous, active-high reset
//   BTN   - raw button level, active-high, asynchronous, may bounce
//   COUNT - registered count of accepted presses, wraps modulo 2^WIDTH
//   PRESS - registered one-cycle pulse in the cycle after a press is accepted
//   LEVEL - registered debounced button level
module debounce_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = 1023
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN,
  output logic [WIDTH-1:0] COUNT,
  output logic             PRESS,
  output logic             LEVEL
);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } state_t;

  localparam logic [31:0]      Threshold = 32'(DEBOUNCE);
  localparam logic [WIDTH-1:0] CountOne  = WIDTH'(1);

  state_t      state;
  logic [31:0] timer;
  logic        s;

`ifdef DEBOUNCE_COUNTER_SYNC_EN
  logic sync_meta;
  logic sync_out;

  // Two-flop synchronizer; BTN is asynchronous to CLK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= BTN;
      sync_out  <= sync_meta;
    end
  end

  assign s = sync_out;
`else
  assign s = BTN;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= StIdle;
      timer <= 32'd0;
      COUNT <= '0;
      PRESS <= 1'b0;
      LEVEL <= 1'b0;
    end else begin
      // PRESS is a single-cycle pulse; only the accepting transition raises it.
      PRESS <= 1'b0;
      unique case (state)
        StIdle: begin
          if (s) begin
            state <= StPressWait;
            timer <= 32'd0;
          end
        end

        StPressWait: begin
          if (!s) begin
            state <= StIdle;
          end else if (timer == Threshold) begin
            state <= StHeld;
            LEVEL <= 1'b1;
            PRESS <= 1'b1;
            COUNT <= COUNT + CountOne;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        StHeld: begin
          if (!s) begin
            state <= StReleaseWait;
            timer <= 32'd0;
          end
        end

        StReleaseWait: begin
          if (s) begin
            state <= StHeld;
          end else if (timer == Threshold) begin
            state <= StIdle;
            LEVEL <= 1'b0;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        default: begin
          state <= StIdle;
          timer <= 32'd0;
        end
      endcase
    end
  end

endmodule
